// File: rtl/reg_bank4x16_seq.sv
// Four-entry 16-bit register bank with a free-running select sequencer.
// The entries drive a downstream 4-way mux directly; S picks the mux input,
// rd_data mirrors the mux result locally, dirty tracks entries written since
// they were last scanned, and wrap pulses once per full pass of S.
module reg_bank4x16_seq #(
    parameter logic [15:0] INIT_VAL = 16'h0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        wr_en,
    input  logic [1:0]  wr_addr,
    input  logic [15:0] wr_data,
    input  logic        scan_en,
    output logic [1:0]  S,
    output logic [15:0] A,
    output logic [15:0] B,
    output logic [15:0] C,
    output logic [15:0] D,
    output logic [15:0] rd_data,
    output logic [3:0]  dirty,
    output logic        wrap
);

    logic [15:0] regs_q [4];
    logic [15:0] regs_d [4];
    logic [1:0]  sel_q;
    logic [1:0]  sel_d;
    logic [3:0]  dirty_q;
    logic [3:0]  dirty_d;
    logic        wrap_q;
    logic        wrap_d;

    // Next-state: at most one entry written, sequencer advance, dirty tracking.
    always_comb begin
        regs_d  = regs_q;
        sel_d   = sel_q;
        dirty_d = dirty_q;
        wrap_d  = 1'b0;

        if (wr_en) begin
            regs_d[wr_addr] = wr_data;
        end

        if (scan_en) begin
            sel_d            = sel_q + 2'd1;
            wrap_d           = (sel_q == 2'd3);
            dirty_d[sel_q]   = 1'b0;
        end

        // Applied after the scan clear so a coincident write keeps the bit set.
        if (wr_en) begin
            dirty_d[wr_addr] = 1'b1;
        end
    end

    // State registers; synchronous reset overrides any write or scan.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) begin
                regs_q[i] <= INIT_VAL;
            end
            sel_q   <= 2'd0;
            dirty_q <= 4'b0000;
            wrap_q  <= 1'b0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                regs_q[i] <= regs_d[i];
            end
            sel_q   <= sel_d;
            dirty_q <= dirty_d;
            wrap_q  <= wrap_d;
        end
    end

    // Local copy of the downstream mux result; no write bypass.
    always_comb begin
        rd_data = regs_q[0];
        case (sel_q)
            2'd0: rd_data = regs_q[0];
            2'd1: rd_data = regs_q[1];
            2'd2: rd_data = regs_q[2];
            2'd3: rd_data = regs_q[3];
            default: rd_data = regs_q[0];
        endcase
    end

    assign A     = regs_q[0];
    assign B     = regs_q[1];
    assign C     = regs_q[2];
    assign D     = regs_q[3];
    assign S     = sel_q;
    assign dirty = dirty_q;
    assign wrap  = wrap_q;

endmodule

// File: tb/tb_reg_bank4x16_seq.sv
// Directed bench for reg_bank4x16_seq: writes, scanning, dirty set/clear
// priority, reset priority, and agreement with a downstream 4-way mux.
module tb_reg_bank4x16_seq;

    localparam logic [15:0] INIT = 16'hA5A5;

    logic        clk;
    logic        reset;
    logic        wr_en;
    logic [1:0]  wr_addr;
    logic [15:0] wr_data;
    logic        scan_en;
    logic [1:0]  S;
    logic [15:0] A, B, C, D;
    logic [15:0] rd_data;
    logic [3:0]  dirty;
    logic        wrap;
    logic [15:0] mux_y;

    int n_checks = 0;
    int n_fail   = 0;

    reg_bank4x16_seq #(.INIT_VAL(INIT)) dut (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .scan_en (scan_en),
        .S       (S),
        .A       (A),
        .B       (B),
        .C       (C),
        .D       (D),
        .rd_data (rd_data),
        .dirty   (dirty),
        .wrap    (wrap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Downstream MUX4WAY16 fed by the block's S and A..D.
    always_comb begin
        mux_y = A;
        case (S)
            2'd0: mux_y = A;
            2'd1: mux_y = B;
            2'd2: mux_y = C;
            2'd3: mux_y = D;
            default: mux_y = A;
        endcase
    end

    task automatic check_val(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Present inputs at the falling edge, clock once, return at the next falling edge.
    task automatic step(input logic rst, input logic we, input logic [1:0] addr,
                        input logic [15:0] data, input logic sc);
        reset   = rst;
        wr_en   = we;
        wr_addr = addr;
        wr_data = data;
        scan_en = sc;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check_regs(input string tag, input logic [15:0] ea, input logic [15:0] eb,
                              input logic [15:0] ec, input logic [15:0] ed);
        check_val({tag, "_A"}, A, ea);
        check_val({tag, "_B"}, B, eb);
        check_val({tag, "_C"}, C, ec);
        check_val({tag, "_D"}, D, ed);
    endtask

    logic [15:0] exp_regs [4];
    logic [1:0]  exp_s;
    logic [15:0] exp_rd  [4];
    logic [1:0]  exp_sq  [4];
    logic [3:0]  exp_dt  [4];

    initial begin
        reset = 1'b1; wr_en = 1'b0; wr_addr = 2'd0; wr_data = 16'h0; scan_en = 1'b0;
        @(negedge clk);
        step(1'b1, 1'b0, 2'd0, 16'h0, 1'b0);
        step(1'b1, 1'b0, 2'd0, 16'h0, 1'b0);

        check_regs("rst", INIT, INIT, INIT, INIT);
        check_val("rst_S", {14'd0, S}, 16'd0);
        check_val("rst_dirty", {12'd0, dirty}, 16'd0);
        check_val("rst_wrap", {15'd0, wrap}, 16'd0);
        check_val("rst_rd", rd_data, INIT);

        // Fill the bank with scanning off.
        step(1'b0, 1'b1, 2'd0, 16'hF000, 1'b0);
        check_regs("wr0", 16'hF000, INIT, INIT, INIT);
        check_val("wr0_dirty", {12'd0, dirty}, 16'h0001);
        step(1'b0, 1'b1, 2'd1, 16'h0F00, 1'b0);
        step(1'b0, 1'b1, 2'd2, 16'h00F0, 1'b0);
        step(1'b0, 1'b1, 2'd3, 16'h000F, 1'b0);
        check_regs("fill", 16'hF000, 16'h0F00, 16'h00F0, 16'h000F);
        check_val("fill_S", {14'd0, S}, 16'd0);
        check_val("fill_rd", rd_data, 16'hF000);
        check_val("fill_dirty", {12'd0, dirty}, 16'h000F);

        // Scan a full pass.
        exp_rd[0] = 16'h0F00; exp_rd[1] = 16'h00F0; exp_rd[2] = 16'h000F; exp_rd[3] = 16'hF000;
        exp_sq[0] = 2'd1; exp_sq[1] = 2'd2; exp_sq[2] = 2'd3; exp_sq[3] = 2'd0;
        exp_dt[0] = 4'b1110; exp_dt[1] = 4'b1100; exp_dt[2] = 4'b1000; exp_dt[3] = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b0, 2'd0, 16'h0, 1'b1);
            check_val($sformatf("scan%0d_S", i), {14'd0, S}, {14'd0, exp_sq[i]});
            check_val($sformatf("scan%0d_rd", i), rd_data, exp_rd[i]);
            check_val($sformatf("scan%0d_dirty", i), {12'd0, dirty}, {12'd0, exp_dt[i]});
            check_val($sformatf("scan%0d_wrap", i), {15'd0, wrap}, (i == 3) ? 16'd1 : 16'd0);
        end
        step(1'b0, 1'b0, 2'd0, 16'h0, 1'b0);
        check_val("hold_S", {14'd0, S}, 16'd0);
        check_val("hold_wrap", {15'd0, wrap}, 16'd0);

        // Advance to S=2, then write R2 while scanning it.
        step(1'b0, 1'b0, 2'd0, 16'h0, 1'b1);
        step(1'b0, 1'b0, 2'd0, 16'h0, 1'b1);
        check_val("pre_S", {14'd0, S}, 16'd2);
        reset = 1'b0; wr_en = 1'b1; wr_addr = 2'd2; wr_data = 16'h1234; scan_en = 1'b1;
        #1;
        check_val("nobypass_rd", rd_data, 16'h00F0);
        @(posedge clk);
        @(negedge clk);
        check_val("setwin_C", C, 16'h1234);
        check_val("setwin_S", {14'd0, S}, 16'd3);
        check_val("setwin_dirty", {12'd0, dirty}, 16'h0004);
        check_val("setwin_rd", rd_data, 16'h000F);

        // Reset while S=3 and scanning.
        step(1'b1, 1'b0, 2'd0, 16'h0, 1'b1);
        check_val("midrst_S", {14'd0, S}, 16'd0);
        check_val("midrst_wrap", {15'd0, wrap}, 16'd0);
        check_val("midrst_dirty", {12'd0, dirty}, 16'd0);
        check_regs("midrst", INIT, INIT, INIT, INIT);

        // Write presented with reset is discarded.
        step(1'b1, 1'b1, 2'd1, 16'hABCD, 1'b0);
        check_val("rstwr_B", B, INIT);
        check_val("rstwr_dirty", {12'd0, dirty}, 16'd0);

        // Writes to other entries do not disturb clearing of dirty[S].
        step(1'b0, 1'b1, 2'd1, 16'h1111, 1'b0);
        check_val("d25a", {12'd0, dirty}, 16'h0002);
        step(1'b0, 1'b1, 2'd3, 16'h3333, 1'b1);
        check_val("d25b", {12'd0, dirty}, 16'h000A);
        step(1'b0, 1'b1, 2'd0, 16'h0001, 1'b1);
        check_val("d25c", {12'd0, dirty}, 16'h0009);
        check_val("d25_S", {14'd0, S}, 16'd2);

        // Eight scan cycles against the downstream mux and a reference model.
        exp_regs[0] = 16'h0001; exp_regs[1] = 16'h1111; exp_regs[2] = INIT; exp_regs[3] = 16'h3333;
        exp_s = 2'd2;
        for (int i = 0; i < 8; i++) begin
            logic was3;
            was3 = (exp_s == 2'd3);
            step(1'b0, 1'b0, 2'd0, 16'h0, 1'b1);
            exp_s = exp_s + 2'd1;
            check_val($sformatf("mux%0d_y", i), mux_y, rd_data);
            check_val($sformatf("mux%0d_rd", i), rd_data, exp_regs[exp_s]);
            check_val($sformatf("mux%0d_wrap", i), {15'd0, wrap}, {15'd0, was3});
        end
        check_val("final_dirty", {12'd0, dirty}, 16'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
